gpio_debounce_n: RTL

GPIO_DEBOUNCE_N -- requirements
Module: gpio_debounce_n

---
 rtl/gpio_debounce_pkg.sv | 26 ++
 rtl/gpio_debounce_n_chan.sv | 65 ++++++
 rtl/gpio_debounce_n.sv | 73 +++++++
 3 files changed

// File: rtl/gpio_debounce_pkg.sv
// Shared defaults, legal parameter ranges and the sample-tick terminal count
// calculation for the gpio_debounce_n block.
package gpio_debounce_pkg;

   localparam int DEF_NUM_CH                 = 22;
   localparam int DEF_CLK_FREQUENCY_HZ       = 50_000_000;
   localparam int DEF_DEBOUNCE_FREQUENCY_HZ  = 250;
   localparam int DEF_SAMPLE_DEPTH           = 4;
   localparam int DEF_CNTR_WIDTH             = 32;
   localparam int DEF_SIMULATE_FREQUENCY_CNT = 5;

   localparam int MAX_NUM_CH       = 64;
   localparam int MAX_SAMPLE_DEPTH = 16;

   // Tick period is top_cnt+1 clocks; simulation builds use a tiny period.
   function automatic longint unsigned calc_top_cnt(
      input int              simulate,
      input longint unsigned sim_cnt,
      input longint unsigned clk_hz,
      input longint unsigned tick_hz
   );
      if (simulate != 0) return sim_cnt;
      return (clk_hz / tick_hz) - 64'd1;
   endfunction

endpackage

// File: rtl/gpio_debounce_n_chan.sv
// One debounced input channel: 2-flop synchronizer, sample history, level and
// optional edge strobes (edge logic present only with GPIO_DEBOUNCE_EDGE_EN).
module debounce_chan
   import gpio_debounce_pkg::*;
#(
   parameter int   SAMPLE_DEPTH = DEF_SAMPLE_DEPTH,
   parameter logic RESET_VAL    = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_tick,
   input  logic i_sig,
   output logic o_db,
   output logic o_rise,
   output logic o_fall
);

   logic [1:0]              r_sync;
   logic [SAMPLE_DEPTH-1:0] r_hist;
   logic                    r_db;
   logic                    w_all1;
   logic                    w_all0;

   assign w_all1 = &r_hist;
   assign w_all0 = ~|r_hist;

   // History resets to the replicated reset level so reset never looks like a change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= {2{RESET_VAL}};
         r_hist <= {SAMPLE_DEPTH{RESET_VAL}};
         r_db   <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[0], i_sig};
         if (i_tick) r_hist <= {r_hist[SAMPLE_DEPTH-2:0], r_sync[1]};
         if (w_all1)      r_db <= 1'b1;
         else if (w_all0) r_db <= 1'b0;
      end
   end

   assign o_db = r_db;

`ifdef GPIO_DEBOUNCE_EDGE_EN
   logic r_rise;
   logic r_fall;

   // Strobes are registered alongside r_db so they coincide with the level change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_all1 & ~r_db;
         r_fall <= w_all0 &  r_db;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/gpio_debounce_n.sv
// Multi-channel GPIO debouncer: shared sample-tick generator plus NUM_CH
// debounce_chan instances. Edge strobes enabled by defining GPIO_DEBOUNCE_EDGE_EN.
module gpio_debounce_n
   import gpio_debounce_pkg::*;
#(
   parameter int                NUM_CH                 = DEF_NUM_CH,
   parameter int                CLK_FREQUENCY_HZ       = DEF_CLK_FREQUENCY_HZ,
   parameter int                DEBOUNCE_FREQUENCY_HZ  = DEF_DEBOUNCE_FREQUENCY_HZ,
   parameter int                SAMPLE_DEPTH           = DEF_SAMPLE_DEPTH,
   parameter int                CNTR_WIDTH             = DEF_CNTR_WIDTH,
   parameter int                SIMULATE               = 0,
   parameter int                SIMULATE_FREQUENCY_CNT = DEF_SIMULATE_FREQUENCY_CNT,
   parameter logic [NUM_CH-1:0] RESET_VALUE            = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] sig_in,
   output logic [NUM_CH-1:0] sig_db,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic              sample_tick
);

   localparam longint unsigned TOP_CNT = calc_top_cnt(SIMULATE, 64'(SIMULATE_FREQUENCY_CNT),
                                                      64'(CLK_FREQUENCY_HZ),
                                                      64'(DEBOUNCE_FREQUENCY_HZ));
   localparam logic [CNTR_WIDTH-1:0] TOP = CNTR_WIDTH'(TOP_CNT);

   if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH) begin : g_err_ch
      $error("gpio_debounce_n: NUM_CH out of range");
   end
   if (SAMPLE_DEPTH < 2 || SAMPLE_DEPTH > MAX_SAMPLE_DEPTH) begin : g_err_depth
      $error("gpio_debounce_n: SAMPLE_DEPTH out of range");
   end
   if ((TOP_CNT >> CNTR_WIDTH) != 0) begin : g_err_cnt
      $error("gpio_debounce_n: tick terminal count does not fit CNTR_WIDTH");
   end

   logic [CNTR_WIDTH-1:0] r_cnt;
   logic [CNTR_WIDTH-1:0] w_cnt_nxt;
   logic                  r_tick;

   assign w_cnt_nxt = (r_cnt == TOP) ? '0 : r_cnt + CNTR_WIDTH'(1);

   // r_tick is registered from the next count, so it is high exactly while r_cnt == TOP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_tick <= (w_cnt_nxt == TOP);
      end
   end

   assign sample_tick = r_tick;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_chan #(
         .SAMPLE_DEPTH (SAMPLE_DEPTH),
         .RESET_VAL    (RESET_VALUE[i])
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .i_tick  (r_tick),
         .i_sig   (sig_in[i]),
         .o_db    (sig_db[i]),
         .o_rise  (rise_pulse[i]),
         .o_fall  (fall_pulse[i])
      );
   end

endmodule
